// File: rtl/rib_wdt_pkg.sv
// Shared RIB watchdog definitions: register offsets, bit positions, kick key,
// FSM encodings and the s6 slave base address.
package rib_wdt_pkg;

    localparam logic [31:0] WDT_S6_BASE    = 32'h0000_6000;

    localparam logic [7:0]  WDT_OFF_CTRL   = 8'h00;
    localparam logic [7:0]  WDT_OFF_LOAD   = 8'h04;
    localparam logic [7:0]  WDT_OFF_COUNT  = 8'h08;
    localparam logic [7:0]  WDT_OFF_KICK   = 8'h0C;
    localparam logic [7:0]  WDT_OFF_STATUS = 8'h10;
    localparam logic [7:0]  WDT_OFF_WINDOW = 8'h14;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_INT_EN      = 1;
    localparam int CTRL_RST_EN      = 2;
    localparam int CTRL_LOCK        = 3;
    localparam int STATUS_INT_PEND  = 0;
    localparam int STATUS_BITE_SEEN = 1;

    localparam logic [31:0] WDT_KICK_KEY = 32'h5A5A_A5A5;

    localparam logic [1:0] WDT_IDLE = 2'd0;
    localparam logic [1:0] WDT_RUN  = 2'd1;
    localparam logic [1:0] WDT_WARN = 2'd2;
    localparam logic [1:0] WDT_BITE = 2'd3;

endpackage

// File: rtl/rib_wdt_if.sv
// RIB slave-slot bundle for the watchdog: write strobe, address, data and the
// interrupt / reset-request outputs back to the SoC.
interface rib_wdt_if;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        int_sig_o;
    logic        rst_req_o;

    modport master (output we_i, addr_i, data_i, input data_o, int_sig_o, rst_req_o);
    modport slave  (input we_i, addr_i, data_i, output data_o, int_sig_o, rst_req_o);
endinterface

// File: rtl/rib_wdt.sv
// Register-mapped watchdog: countdown, warning interrupt, then a fixed-width
// reset request. Optional kick window enabled with `define WDT_WINDOW_EN.
module rib_wdt
    import rib_wdt_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned RST_PULSE = 16,
    parameter logic [31:0] KICK_KEY  = WDT_KICK_KEY
) (
    input  logic     clk,
    input  logic     rst,
    rib_wdt_if.slave bus
);
    localparam int unsigned PW = $clog2(RST_PULSE + 1);

    logic [1:0]           state_reg;
    logic [CNT_WIDTH-1:0] count_reg;
    logic [CNT_WIDTH-1:0] load_reg;
    logic [3:0]           ctrl_reg;
    logic                 int_pend_reg;
    logic                 bite_seen_reg;
    logic [PW-1:0]        pulse_reg;

    logic [7:0]  off;
    logic        running, count_zero, ctrl_wr, load_wr, status_wr;
    logic        kick_req, kick_ok, win_viol, disable_req;
    logic        enter_bite, set_pend, bite_done;
    logic [31:0] count_ext, load_ext;
    logic        unused_addr;

    assign off         = bus.addr_i[7:0];
    assign unused_addr = ^bus.addr_i[31:8];
    assign running     = (state_reg == WDT_RUN) || (state_reg == WDT_WARN);
    assign count_zero  = (count_reg == '0);
    assign ctrl_wr     = bus.we_i && (off == WDT_OFF_CTRL) && !ctrl_reg[CTRL_LOCK] && (state_reg != WDT_BITE);
    assign load_wr     = bus.we_i && (off == WDT_OFF_LOAD) && !ctrl_reg[CTRL_LOCK] && (state_reg != WDT_BITE);
    assign status_wr   = bus.we_i && (off == WDT_OFF_STATUS);
    assign kick_req    = bus.we_i && (off == WDT_OFF_KICK) && (bus.data_i == KICK_KEY) && running;
    assign kick_ok     = kick_req && !win_viol;
    assign disable_req = ctrl_wr && !bus.data_i[CTRL_EN];
    assign bite_done   = (state_reg == WDT_BITE) && (pulse_reg == PW'(RST_PULSE - 1));

`ifdef WDT_WINDOW_EN
    logic [CNT_WIDTH-1:0] window_reg;
    logic [31:0]          window_ext;
    logic                 window_wr;

    assign window_wr = bus.we_i && (off == WDT_OFF_WINDOW) && !ctrl_reg[CTRL_LOCK] && (state_reg != WDT_BITE);
    // A key that arrives too early (count still above the window) is a violation.
    assign win_viol  = kick_req && (count_reg > window_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            window_reg <= '1;
        end else if (window_wr) begin
            window_reg <= bus.data_i[CNT_WIDTH-1:0];
        end
    end
`else
    assign win_viol = 1'b0;
`endif

    // Zero-extend the CNT_WIDTH registers onto the 32-bit read bus.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_ext
            if (gi < CNT_WIDTH) begin : g_bit
                assign count_ext[gi] = count_reg[gi];
                assign load_ext[gi]  = load_reg[gi];
`ifdef WDT_WINDOW_EN
                assign window_ext[gi] = window_reg[gi];
`endif
            end else begin : g_zero
                assign count_ext[gi] = 1'b0;
                assign load_ext[gi]  = 1'b0;
`ifdef WDT_WINDOW_EN
                assign window_ext[gi] = 1'b0;
`endif
            end
        end
    endgenerate

    // Timeout and violation outcomes, shared by the FSM and the status bits.
    always_comb begin
        enter_bite = 1'b0;
        set_pend   = 1'b0;
        if (running && !disable_req) begin
            if (win_viol) begin
                if (ctrl_reg[CTRL_RST_EN]) enter_bite = 1'b1;
                else                       set_pend   = 1'b1;
            end else if (!kick_ok && count_zero) begin
                if ((state_reg == WDT_WARN) && ctrl_reg[CTRL_RST_EN]) enter_bite = 1'b1;
                else                                                  set_pend   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= WDT_IDLE;
            count_reg <= '0;
            pulse_reg <= '0;
        end else begin
            case (state_reg)
                WDT_IDLE: begin
                    if (ctrl_wr && bus.data_i[CTRL_EN]) begin
                        state_reg <= WDT_RUN;
                        count_reg <= load_reg;
                    end
                end
                WDT_RUN, WDT_WARN: begin
                    if (disable_req) begin
                        state_reg <= WDT_IDLE;
                    end else if (enter_bite) begin
                        state_reg <= WDT_BITE;
                        pulse_reg <= '0;
                    end else if (kick_ok) begin
                        state_reg <= WDT_RUN;
                        count_reg <= load_reg;
                    end else if (count_zero) begin
                        state_reg <= WDT_WARN;
                        count_reg <= load_reg;
                    end else begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                WDT_BITE: begin
                    if (bite_done) state_reg <= WDT_IDLE;
                    else           pulse_reg <= pulse_reg + 1'b1;
                end
                default: state_reg <= WDT_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_reg      <= '0;
            load_reg      <= '0;
            int_pend_reg  <= 1'b0;
            bite_seen_reg <= 1'b0;
        end else begin
            if (bite_done) begin
                ctrl_reg[CTRL_EN]   <= 1'b0;
                ctrl_reg[CTRL_LOCK] <= 1'b0;
            end else if (ctrl_wr) begin
                ctrl_reg <= bus.data_i[3:0];
            end
            if (load_wr) load_reg <= bus.data_i[CNT_WIDTH-1:0];
            // Hardware set takes priority over a simultaneous W1C.
            if (set_pend)                                       int_pend_reg <= 1'b1;
            else if (status_wr && bus.data_i[STATUS_INT_PEND])  int_pend_reg <= 1'b0;
            if (enter_bite)                                     bite_seen_reg <= 1'b1;
            else if (status_wr && bus.data_i[STATUS_BITE_SEEN]) bite_seen_reg <= 1'b0;
        end
    end

    always_comb begin
        bus.data_o = 32'd0;
        case (off)
            WDT_OFF_CTRL:   bus.data_o = {28'd0, ctrl_reg};
            WDT_OFF_LOAD:   bus.data_o = load_ext;
            WDT_OFF_COUNT:  bus.data_o = count_ext;
            WDT_OFF_STATUS: bus.data_o = {30'd0, bite_seen_reg, int_pend_reg};
`ifdef WDT_WINDOW_EN
            WDT_OFF_WINDOW: bus.data_o = window_ext;
`endif
            default:        bus.data_o = 32'd0;
        endcase
    end

    assign bus.int_sig_o = int_pend_reg & ctrl_reg[CTRL_INT_EN];
    assign bus.rst_req_o = (state_reg == WDT_BITE);

endmodule

// File: tb/tb_rib_wdt.sv
// Self-checking bench for rib_wdt: register table plus hand-timed sequences for
// warn/recover, bite pulse, bad key, lock, kick-at-zero, LOAD=0 and window.
module tb_rib_wdt;
    import rib_wdt_pkg::*;

    typedef struct {
        string       name;
        logic        we;
        logic [7:0]  off;
        logic [31:0] data;
        logic        chk;
        logic [31:0] exp_rd;
        logic        exp_int;
        logic        exp_rst;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        int_sig;
        logic        rst_req;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t tbl[$];

    rib_wdt_if bus ();

    rib_wdt #(.CNT_WIDTH(32), .RST_PULSE(16), .KICK_KEY(32'h5A5A_A5A5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t wr(input logic [7:0] off, input logic [31:0] data);
        vec_t v;
        v.name = "wr"; v.we = 1'b1; v.off = off; v.data = data;
        v.chk = 1'b0; v.exp_rd = '0; v.exp_int = 1'b0; v.exp_rst = 1'b0;
        return v;
    endfunction

    function automatic vec_t rd(input string name, input logic [7:0] off, input logic [31:0] e,
                                input logic ei, input logic er);
        vec_t v;
        v.name = name; v.we = 1'b0; v.off = off; v.data = '0;
        v.chk = 1'b1; v.exp_rd = e; v.exp_int = ei; v.exp_rst = er;
        return v;
    endfunction

    // One bus cycle: drive at negedge, compare 1ns later, commit at posedge.
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        bus.we_i   = v.we;
        bus.addr_i = WDT_S6_BASE | {24'd0, v.off};
        bus.data_i = v.data;
        if (v.chk) begin
            e.name = v.name; e.rd = v.exp_rd; e.int_sig = v.exp_int; e.rst_req = v.exp_rst;
            sb.push_back(e);
        end
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            if (bus.data_o !== e.rd || bus.int_sig_o !== e.int_sig || bus.rst_req_o !== e.rst_req) begin
                n_err++;
                $display("FAIL %s off=%h: got data_o=%h int=%b rst_req=%b, want data_o=%h int=%b rst_req=%b",
                         e.name, v.off, bus.data_o, bus.int_sig_o, bus.rst_req_o, e.rd, e.int_sig, e.rst_req);
            end else begin
                $display("ok   %s off=%h data_o=%h int=%b rst_req=%b", e.name, v.off, bus.data_o,
                         bus.int_sig_o, bus.rst_req_o);
            end
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        bus.we_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] win_rst_val;
        logic [31:0] win_wr_val;
        bus.we_i = 1'b0; bus.addr_i = '0; bus.data_i = '0;
`ifdef WDT_WINDOW_EN
        win_rst_val = 32'hFFFF_FFFF; win_wr_val = 32'h77;
`else
        win_rst_val = 32'h0;         win_wr_val = 32'h0;
`endif
        // Reset state and plain register access.
        tbl.push_back(rd("rst_ctrl",   WDT_OFF_CTRL,   0, 0, 0));
        tbl.push_back(rd("rst_load",   WDT_OFF_LOAD,   0, 0, 0));
        tbl.push_back(rd("rst_count",  WDT_OFF_COUNT,  0, 0, 0));
        tbl.push_back(rd("rst_kick",   WDT_OFF_KICK,   0, 0, 0));
        tbl.push_back(rd("rst_status", WDT_OFF_STATUS, 0, 0, 0));
        tbl.push_back(rd("rst_window", WDT_OFF_WINDOW, win_rst_val, 0, 0));
        tbl.push_back(rd("rst_unmap",  8'h20,          0, 0, 0));
        tbl.push_back(wr(WDT_OFF_LOAD, 32'h1234));
        tbl.push_back(rd("load_rw",    WDT_OFF_LOAD,   32'h1234, 0, 0));
        tbl.push_back(wr(WDT_OFF_KICK, WDT_KICK_KEY));
        tbl.push_back(rd("idle_kick",  WDT_OFF_COUNT,  0, 0, 0));
        tbl.push_back(wr(8'h20, 32'hFFFF));
        tbl.push_back(rd("unmap_wr",   8'h20,          0, 0, 0));
        tbl.push_back(wr(WDT_OFF_WINDOW, 32'h77));
        tbl.push_back(rd("window_wr",  WDT_OFF_WINDOW, win_wr_val, 0, 0));
        tbl.push_back(wr(WDT_OFF_CTRL, 32'h6));
        tbl.push_back(rd("ctrl_rw",    WDT_OFF_CTRL,   32'h6, 0, 0));
        tbl.push_back(rd("no_en_idle", WDT_OFF_COUNT,  0, 0, 0));
        tbl.push_back(wr(WDT_OFF_CTRL, 32'h0));
        tbl.push_back(rd("ctrl_clr",   WDT_OFF_CTRL,   0, 0, 0));

        reset_dut();
        foreach (tbl[i]) apply(tbl[i]);

        // Warn then recover: interrupt 11 cycles after enable with LOAD=10.
        reset_dut();
        apply(wr(WDT_OFF_LOAD, 32'd10));
        apply(wr(WDT_OFF_CTRL, 32'h3));
        for (int j = 0; j <= 10; j++) apply(rd("run_count", WDT_OFF_COUNT, 32'(10 - j), 0, 0));
        apply(rd("warn_reload", WDT_OFF_COUNT, 32'd10, 1, 0));
        apply(rd("warn_status", WDT_OFF_STATUS, 32'h1, 1, 0));
        apply(wr(WDT_OFF_KICK, WDT_KICK_KEY));
        apply(rd("kick_reload", WDT_OFF_COUNT, 32'd10, 1, 0));
        apply(wr(WDT_OFF_STATUS, 32'h1));
        apply(rd("w1c_pend", WDT_OFF_STATUS, 32'h0, 0, 0));
        apply(wr(WDT_OFF_CTRL, 32'h0));
        apply(rd("disable_hold", WDT_OFF_COUNT, 32'd7, 0, 0));
        apply(rd("disable_hold2", WDT_OFF_COUNT, 32'd7, 0, 0));

        // Bite: rst_req high in slots 12..27, then IDLE with en cleared.
        reset_dut();
        apply(wr(WDT_OFF_LOAD, 32'd5));
        apply(wr(WDT_OFF_CTRL, 32'h5));
        for (int j = 0; j < 30; j++)
            apply(rd("bite_pulse", WDT_OFF_CTRL, (j < 28) ? 32'h5 : 32'h4, 0, (j >= 12 && j <= 27)));
        apply(rd("bite_status", WDT_OFF_STATUS, 32'h3, 0, 0));
        apply(wr(WDT_OFF_KICK, WDT_KICK_KEY));
        apply(rd("post_bite_idle", WDT_OFF_COUNT, 32'd0, 0, 0));

        // Bad key and lock.
        reset_dut();
        apply(wr(WDT_OFF_LOAD, 32'd100));
        apply(wr(WDT_OFF_CTRL, 32'h9));
        apply(wr(WDT_OFF_KICK, 32'h1234_5678));
        apply(rd("bad_key", WDT_OFF_COUNT, 32'd99, 0, 0));
        apply(wr(WDT_OFF_CTRL, 32'h0));
        apply(rd("lock_ctrl", WDT_OFF_COUNT, 32'd97, 0, 0));
        apply(wr(WDT_OFF_LOAD, 32'd5));
        apply(rd("lock_load", WDT_OFF_LOAD, 32'd100, 0, 0));
        apply(rd("lock_ctrl_rd", WDT_OFF_CTRL, 32'h9, 0, 0));
        apply(wr(WDT_OFF_KICK, WDT_KICK_KEY));
        apply(rd("good_key", WDT_OFF_COUNT, 32'd100, 0, 0));

        // Kick in the same cycle COUNT reaches zero.
        reset_dut();
        apply(wr(WDT_OFF_LOAD, 32'd3));
        apply(wr(WDT_OFF_CTRL, 32'h3));
        for (int j = 0; j < 3; j++) apply(rd("pre_zero", WDT_OFF_COUNT, 32'(3 - j), 0, 0));
        apply(wr(WDT_OFF_KICK, WDT_KICK_KEY));
        apply(rd("kick_zero_cnt", WDT_OFF_COUNT, 32'd3, 0, 0));
        apply(rd("kick_zero_stat", WDT_OFF_STATUS, 32'h0, 0, 0));

        // LOAD=0: timeout on the first RUN cycle; set beats W1C.
        reset_dut();
        apply(wr(WDT_OFF_CTRL, 32'h3));
        apply(rd("load0_entry", WDT_OFF_STATUS, 32'h0, 0, 0));
        apply(rd("load0_pend", WDT_OFF_STATUS, 32'h1, 1, 0));
        apply(wr(WDT_OFF_STATUS, 32'h1));
        apply(rd("set_beats_w1c", WDT_OFF_STATUS, 32'h1, 1, 0));

`ifdef WDT_WINDOW_EN
        // Early kick (COUNT=7 > WINDOW=3) bites; late kick (COUNT=2) reloads.
        reset_dut();
        apply(wr(WDT_OFF_WINDOW, 32'd3));
        apply(wr(WDT_OFF_LOAD, 32'd10));
        apply(wr(WDT_OFF_CTRL, 32'h5));
        for (int j = 0; j < 3; j++) apply(rd("win_cnt", WDT_OFF_COUNT, 32'(10 - j), 0, 0));
        apply(wr(WDT_OFF_KICK, WDT_KICK_KEY));
        apply(rd("win_early_bite", WDT_OFF_CTRL, 32'h5, 0, 1));
        reset_dut();
        apply(wr(WDT_OFF_WINDOW, 32'd3));
        apply(wr(WDT_OFF_LOAD, 32'd10));
        apply(wr(WDT_OFF_CTRL, 32'h5));
        for (int j = 0; j < 8; j++) apply(rd("win_cnt2", WDT_OFF_COUNT, 32'(10 - j), 0, 0));
        apply(wr(WDT_OFF_KICK, WDT_KICK_KEY));
        apply(rd("win_late_kick", WDT_OFF_COUNT, 32'd10, 0, 0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
